regfile_mp: RTL and testbench

- Parametrised multi-read-port register file; successor to the CPU's fixed 16x16, 2-read, 1-write regfile.
- Adds configurable width, depth and read-port count, plus optional hardwired-zero register 0 and optional write-to-read bypass.
- Adds a sequential clear engine: zeroes every entry after reset or on request, one entry per cycle.
- Sits in the CPU datapath between decode (read addresses) and writeback (write port).

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_if.sv | 27 ++
 rtl/regfile_clear_fsm.sv | 66 ++++++
 rtl/regfile_mp.sv | 76 +++++++
 tb/tb_regfile_mp.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package regfile_pkg;

  // Clear engine state: CLEAR zeroes one entry per cycle, READY is normal operation.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

  // Number of entries addressed by an addr_w-bit address.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Low bit of port k inside a packed bus of w-bit fields.
  function automatic int slice_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Register file access bundle: one write port, packed read ports, clear control.
// Latency: reads combinational, writes land on the next rising edge.
// Backpressure: busy high means writes are dropped (flagged via wr_err).
interface regfile_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
);
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     clr_req;
  logic                     busy;
  logic                     wr_err;

  modport master (
    output we, waddr, wdata, raddr, clr_req,
    input  rdata, busy, wr_err
  );

  modport slave (
    input  we, waddr, wdata, raddr, clr_req,
    output rdata, busy, wr_err
  );
endinterface

// File: rtl/regfile_clear_fsm.sv
// Clear engine: walks idx over every entry after reset or clr_req, flags dropped writes.
// Latency: DEPTH cycles busy per clear; wr_err is a registered pulse one cycle after the drop.
// Backpressure: busy blocks user writes; clr_req is ignored while clearing.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  input  logic              we,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              wr_err
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              wr_err_nxt;

  // State register; reset restarts the clear from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= CLEAR;
      idx    <= '0;
      wr_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      wr_err <= wr_err_nxt;
    end
  end

  // Next-state: step idx while clearing, leave CLEAR on the last entry (idx wraps to 0).
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      CLEAR: begin
        idx_nxt = idx + 1'b1;
        if (idx == {ADDR_W{1'b1}}) state_nxt = READY;
      end
      READY: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        idx_nxt   = '0;
      end
    endcase
  end

  // Outputs: busy and the clear write port follow state; a write seen while busy is an error.
  always_comb begin
    busy       = (state == CLEAR);
    clr_we     = busy & ~rst;
    clr_addr   = idx;
    wr_err_nxt = busy & we;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD async read ports, one write port, optional r0=0 and bypass.
// Latency: reads zero-cycle (bypass makes same-cycle writes visible), writes on next edge.
// Backpressure: while busy (clearing) reads return 0 and writes are dropped with wr_err.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input logic     clk,
  input logic     rst,
  regfile_if.slave bus
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              usr_we;

  regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (bus.clr_req),
    .we       (bus.we),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .wr_err   (bus.wr_err)
  );

  assign bus.busy = busy;

  // User write qualifier: only in READY, not under reset, and never into a hardwired r0.
  always_comb begin
    usr_we = bus.we & ~busy & ~rst;
    if ((ZERO_REG != 0) && (bus.waddr == '0)) usr_we = 1'b0;
  end

  // Storage write mux: the clear engine owns the port while it runs.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (usr_we) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = bus.raddr[slice_lsb(k, ADDR_W) +: ADDR_W];

    // Per-port read: busy, then hardwired zero, then bypass, then storage.
    always_comb begin
      if (busy) begin
        rd = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
      end else if ((BYPASS != 0) && bus.we && (bus.waddr == ra)) begin
        rd = bus.wdata;
      end else begin
        rd = mem[ra];
      end
    end

    assign bus.rdata[slice_lsb(k, DATA_W) +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two configurations driven in lockstep, checked against a reference model.
// Latency: inputs change on the falling edge, outputs sampled 1ns later.
// Backpressure: clear windows and dropped writes are predicted by the model.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic        we;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic        clr_req;
  logic [3:0]  ra [4];

  int n_cmp;
  int n_err;

  // Reference state: cycles left in the clear window, pending error flag, contents per config.
  int          left;
  bit          err;
  logic [15:0] ma [16];
  logic [15:0] mb [16];

  // Config A: 4 ports, no hardwired zero, bypass on.
  regfile_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(4)) ifa ();
  // Config B: 2 ports, hardwired zero, no bypass.
  regfile_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) ifb ();

  assign ifa.we      = we;
  assign ifa.waddr   = waddr;
  assign ifa.wdata   = wdata;
  assign ifa.clr_req = clr_req;
  assign ifa.raddr   = {ra[3], ra[2], ra[1], ra[0]};
  assign ifb.we      = we;
  assign ifb.waddr   = waddr;
  assign ifb.wdata   = wdata;
  assign ifb.clr_req = clr_req;
  assign ifb.raddr   = {ra[1], ra[0]};

  regfile_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(0), .BYPASS(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_a(input logic [3:0] a);
    if (left > 0) return 16'h0;
    if (we && waddr == a) return wdata;
    return ma[a];
  endfunction

  function automatic logic [15:0] exp_b(input logic [3:0] a);
    if (left > 0) return 16'h0;
    if (a == 4'd0) return 16'h0;
    return mb[a];
  endfunction

  task automatic zero_model();
    for (int i = 0; i < 16; i++) begin
      ma[i] = 16'h0;
      mb[i] = 16'h0;
    end
  endtask

  // Apply the architectural effect of one rising edge with the current inputs.
  task automatic model_edge();
    if (rst) begin
      left = 16;
      err  = 1'b0;
      zero_model();
    end else if (left > 0) begin
      err  = we;
      left = left - 1;
    end else begin
      err = 1'b0;
      if (we) begin
        ma[waddr] = wdata;
        if (waddr != 4'd0) mb[waddr] = wdata;
      end
      if (clr_req) begin
        left = 16;
        zero_model();
      end
    end
  endtask

  // Check every output against the model, then clock once.
  task automatic step();
    #1;
    chk("busy_a", {15'h0, ifa.busy}, {15'h0, left > 0});
    chk("busy_b", {15'h0, ifb.busy}, {15'h0, left > 0});
    chk("wr_err_a", {15'h0, ifa.wr_err}, {15'h0, err});
    chk("wr_err_b", {15'h0, ifb.wr_err}, {15'h0, err});
    for (int k = 0; k < 4; k++)
      chk($sformatf("rdata_a%0d@%h", k, ra[k]), ifa.rdata[k*16 +: 16], exp_a(ra[k]));
    for (int k = 0; k < 2; k++)
      chk($sformatf("rdata_b%0d@%h", k, ra[k]), ifb.rdata[k*16 +: 16], exp_b(ra[k]));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we      = 1'b0;
    clr_req = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic set_ra(input logic [3:0] a);
    for (int k = 0; k < 4; k++) ra[k] = a;
  endtask

  initial begin
    int cnt;
    n_cmp   = 0;
    n_err   = 0;
    left    = 0;
    err     = 1'b0;
    zero_model();
    rst     = 1'b1;
    we      = 1'b0;
    waddr   = 4'd0;
    wdata   = 16'h0;
    clr_req = 1'b0;
    set_ra(4'd0);

    // Reset for one edge, then a full clear must follow.
    @(posedge clk);
    model_edge();
    @(negedge clk);
    idle();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 4; k++) ra[k] = 4'($urandom_range(0, 15));
      cnt += int'(ifa.busy);
      step();
    end
    chk("reset_busy_cycles", 16'(cnt), 16'd16);
    for (int i = 0; i < 16; i++) begin
      set_ra(4'(i));
      step();
    end

    // Write r5 while reading r5 and r3.
    we = 1'b1; waddr = 4'd5; wdata = 16'hBEEF;
    ra[0] = 4'd5; ra[1] = 4'd3;
    #1;
    chk("bypass_same_cycle", ifa.rdata[15:0], 16'hBEEF);
    chk("nobypass_same_cycle", ifb.rdata[15:0], 16'h0000);
    step();
    we = 1'b0;
    #1;
    chk("nobypass_next_cycle", ifb.rdata[15:0], 16'hBEEF);
    chk("other_port_r3", ifb.rdata[31:16], 16'h0000);
    step();

    // Write to r0: hardwired in config B, ordinary in config A.
    we = 1'b1; waddr = 4'd0; wdata = 16'h1234;
    set_ra(4'd0);
    step();
    we = 1'b0;
    #1;
    chk("r0_hardwired", ifb.rdata[15:0], 16'h0000);
    chk("r0_plain", ifa.rdata[15:0], 16'h1234);
    step();

    // Clear request followed by a write that must be dropped.
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      we = (i == 0); waddr = 4'd7; wdata = 16'hAAAA;
      set_ra(4'd7);
      cnt += int'(ifa.busy);
      step();
      if (i == 0) chk("dropped_wr_err", {15'h0, ifa.wr_err}, 16'h1);
    end
    chk("clr_busy_cycles", 16'(cnt), 16'd16);
    chk("r7_after_clear", ifa.rdata[15:0], 16'h0000);

    // Reset in the middle of a clear restarts it.
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; waddr = 4'(i + 8); wdata = 16'(16'h1111 * (i + 1));
      step();
    end
    idle();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cnt += int'(ifa.busy);
      step();
    end
    chk("midclear_busy_cycles", 16'(cnt), 16'd16);
    for (int i = 0; i < 16; i++) begin
      set_ra(4'(i));
      step();
    end

    // All four ports on r2, then a bypassed write to r2.
    we = 1'b1; waddr = 4'd2; wdata = 16'h00FF;
    step();
    we = 1'b0;
    set_ra(4'd2);
    step();
    we = 1'b1; wdata = 16'h0F0F;
    #1;
    for (int k = 0; k < 4; k++)
      chk($sformatf("quad_bypass_%0d", k), ifa.rdata[k*16 +: 16], 16'h0F0F);
    step();
    idle();

    // Randomised traffic with occasional clears and resets.
    for (int i = 0; i < 400; i++) begin
      we      = ($urandom_range(0, 1) == 1);
      waddr   = 4'($urandom_range(0, 15));
      wdata   = 16'($urandom);
      clr_req = ($urandom_range(0, 39) == 0);
      rst     = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < 4; k++)
        ra[k] = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
      step();
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
